// File: rtl/ram_pkg.sv
// Shared types and helpers for the dual-port byte-enable RAM.
package ram_pkg;

    // Clear sequencer states.
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Same-address read/write collision policy.
    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    // Byte-lane merge: take the new byte when its enable is set.
    function automatic logic [7:0] merge_be(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       be);
        return be ? new_b : old_b;
    endfunction

endpackage

// File: rtl/ram_init_seq.sv
// Post-reset clear sequencer: walks every address once, then idles in READY.
module ram_init_seq
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 4,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  init_busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    state_t                state;
    logic [ADDR_WIDTH-1:0] clr_cnt;

    // Step the clear counter; leave CLEAR after the last address is written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            clr_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (&clr_cnt) state <= ST_READY;
        end
    end

    assign init_busy = (state == ST_CLEAR);
    assign clr_we    = init_busy;
    assign clr_addr  = clr_cnt;

endmodule

// File: rtl/ram_dp_be.sv
// Simple-dual-port RAM with byte enables, 1/2-cycle read latency,
// selectable collision policy and a post-reset hardware clear.
module ram_dp_be
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 16,
    parameter int RD_LATENCY     = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    init_busy
);

    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    localparam int NUM_BYTES = DATA_WIDTH / 8;

    // Reject configurations the byte lanes and read pipe cannot express.
    if ((DATA_WIDTH % 8) != 0) begin : g_bad_dw
        $error("ram_dp_be: DATA_WIDTH must be a multiple of 8");
    end
    if ((RD_LATENCY < 1) || (RD_LATENCY > 2)) begin : g_bad_lat
        $error("ram_dp_be: RD_LATENCY must be 1 or 2");
    end

    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;

    ram_init_seq #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_init (
        .clk       (clk),
        .rst       (rst),
        .init_busy (init_busy),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr)
    );

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // User requests are only honoured once the clear has finished.
    logic rd_acc, wr_acc;
    assign rd_acc = rd_en & ~init_busy;
    assign wr_acc = wr_en & ~init_busy;

    // The clear sequencer borrows the write port while busy.
    logic                  w_en;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic [NUM_BYTES-1:0]  w_be;
    assign w_en   = init_busy ? clr_we   : wr_acc;
    assign w_addr = init_busy ? clr_addr : wr_addr;
    assign w_data = init_busy ? '0       : wr_data;
    assign w_be   = init_busy ? '1       : wr_be;

    // Byte-lane array write; the array itself has no reset.
    always_ff @(posedge clk) begin
        if (w_en) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (w_be[i]) mem[w_addr][8*i +: 8] <= w_data[8*i +: 8];
            end
        end
    end

    // Write-first collision word: enabled lanes from wr_data, rest from the array.
    logic [NUM_BYTES-1:0][7:0] coll_word;
    for (genvar i = 0; i < NUM_BYTES; i++) begin : g_lane
        assign coll_word[i] = merge_be(mem[rd_addr][8*i +: 8], wr_data[8*i +: 8], wr_be[i]);
    end

    logic                  rdw_hit;
    logic [DATA_WIDTH-1:0] rd_word;
    assign rdw_hit = (RDW_MODE == RDW_WRITE_FIRST) && wr_acc && (wr_addr == rd_addr);
    assign rd_word = rdw_hit ? coll_word : mem[rd_addr];

    // Read pipe: stage 0 captures the array word, later stages only shift real reads
    // so rd_data holds its last value between completions.
    logic [RD_LATENCY-1:0]                 vld_pipe;
    logic [RD_LATENCY-1:0][DATA_WIDTH-1:0] data_pipe;

    // Read pipeline registers, flushed by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe  <= '0;
            data_pipe <= '0;
        end else begin
            vld_pipe[0] <= rd_acc;
            if (rd_acc) data_pipe[0] <= rd_word;
            for (int k = 1; k < RD_LATENCY; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                if (vld_pipe[k-1]) data_pipe[k] <= data_pipe[k-1];
            end
        end
    end

    assign rd_valid = vld_pipe[RD_LATENCY-1];
    assign rd_data  = data_pipe[RD_LATENCY-1];

endmodule

// File: tb/tb_ram_dp_be.sv
// Bench for ram_dp_be: two configurations (latency 1/read-first and
// latency 2/write-first) share one stimulus stream and one array model.
module tb_ram_dp_be;

    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0, rd_en = 1'b0;
    logic [AW-1:0] wr_addr = '0, rd_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [NB-1:0] wr_be = '0;
    logic [DW-1:0] rd_data0, rd_data1;
    logic          rd_valid0, rd_valid1, busy0, busy1;

    always #5 clk = ~clk;

    ram_dp_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)) dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0), .init_busy(busy0));

    ram_dp_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(1)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1), .init_busy(busy1));

    // Model: plain word array, a count of remaining clear cycles, and the
    // expected output of each DUT (plus the one pending stage of the slow one).
    logic [DW-1:0] mm [DEPTH];
    int            clr_left = 0;
    logic          ev [2];
    logic [DW-1:0] ed [2];
    logic          pv;
    logic [DW-1:0] pd;
    int            total = 0;
    int            bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Predict the effect of the coming edge, take it, then compare every output.
    task automatic tick();
        logic          busy, racc, wacc;
        logic [DW-1:0] old_w, new_w, r0, r1;
        if (!rst) begin
            busy  = (clr_left > 0);
            racc  = rd_en && !busy;
            wacc  = wr_en && !busy;
            old_w = mm[rd_addr];
            new_w = mm[wr_addr];
            for (int i = 0; i < NB; i++)
                if (wr_be[i]) new_w[8*i +: 8] = wr_data[8*i +: 8];
            r0 = old_w;
            r1 = (wacc && wr_addr == rd_addr) ? new_w : old_w;
            ev[0] = racc;
            if (racc) ed[0] = r0;
            ev[1] = pv;
            if (pv) ed[1] = pd;
            pv = racc;
            if (racc) pd = r1;
            if (wacc) mm[wr_addr] = new_w;
            if (clr_left > 0) clr_left--;
        end
        @(posedge clk);
        #1;
        chk("busy0", 32'(busy0), 32'(clr_left > 0));
        chk("busy1", 32'(busy1), 32'(clr_left > 0));
        chk("valid0", 32'(rd_valid0), 32'(ev[0]));
        chk("data0", 32'(rd_data0), 32'(ed[0]));
        chk("valid1", 32'(rd_valid1), 32'(ev[1]));
        chk("data1", 32'(rd_data1), 32'(ed[1]));
    endtask

    task automatic idle();
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be; rd_en = 1'b0;
        tick();
        idle();
    endtask

    task automatic rd(input logic [AW-1:0] a);
        rd_en = 1'b1; rd_addr = a; wr_en = 1'b0;
        tick();
        idle();
    endtask

    // Assert reset mid-cycle; outputs must clear without waiting for an edge.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_valid0", 32'(rd_valid0), 32'd0);
        chk("rst_data0", 32'(rd_data0), 32'd0);
        chk("rst_valid1", 32'(rd_valid1), 32'd0);
        chk("rst_data1", 32'(rd_data1), 32'd0);
        ev[0] = 1'b0; ev[1] = 1'b0; ed[0] = '0; ed[1] = '0; pv = 1'b0; pd = '0;
        for (int i = 0; i < DEPTH; i++) mm[i] = '0;
        clr_left = DEPTH;
        idle();
        repeat (2) tick();
    endtask

    // Release reset and count busy cycles, bounded.
    task automatic release_and_clear(output int n);
        rst = 1'b0;
        n = 0;
        while (busy0 && n < 40) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        // 1: clear length and all-zero contents
        do_reset();
        release_and_clear(n);
        chk("clr_len_first", 32'(n), 32'd16);
        for (int a = 0; a < DEPTH; a++) begin
            rd_en = 1'b1; rd_addr = AW'(a);
            tick();
            chk("zero_rd", {15'd0, rd_valid0, rd_data0}, 32'h0001_0000);
        end
        idle();
        tick();

        // 2: basic writes and the latency shift between configurations
        wr(4'd2, 16'hAAAA, 2'b11);
        wr(4'd4, 16'h5555, 2'b11);
        rd(4'd2);
        chk("lat1_a", 32'(rd_data0), 32'h0000_AAAA);
        rd(4'd4);
        chk("lat1_b", 32'(rd_data0), 32'h0000_5555);
        chk("lat2_a", 32'(rd_data1), 32'h0000_AAAA);
        tick();
        chk("lat2_b", 32'(rd_data1), 32'h0000_5555);
        chk("hold0", {15'd0, rd_valid0, rd_data0}, 32'h0000_5555);

        // 3: partial byte write
        wr(4'd7, 16'h1234, 2'b11);
        wr(4'd7, 16'hFF00, 2'b10);
        rd(4'd7);
        chk("be_merge0", 32'(rd_data0), 32'h0000_FF34);
        tick();
        chk("be_merge1", 32'(rd_data1), 32'h0000_FF34);

        // 4: same-address collision, both policies
        wr(4'd3, 16'h0101, 2'b11);
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hBEEF; wr_be = 2'b11;
        rd_en = 1'b1; rd_addr = 4'd3;
        tick();
        idle();
        chk("rdw_first", 32'(rd_data0), 32'h0000_0101);
        tick();
        chk("wr_first", 32'(rd_data1), 32'h0000_BEEF);
        rd(4'd3);
        chk("after_coll0", 32'(rd_data0), 32'h0000_BEEF);
        tick();
        chk("after_coll1", 32'(rd_data1), 32'h0000_BEEF);

        // 5: requests during clear are dropped
        do_reset();
        rst = 1'b0;
        repeat (3) tick();
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h7777; wr_be = 2'b11;
        rd_en = 1'b1; rd_addr = 4'd5;
        tick();
        idle();
        chk("busy_drop_v", 32'(rd_valid0), 32'd0);
        n = 0;
        while (busy0 && n < 40) begin
            tick();
            n++;
        end
        chk("busy_drop_v1", 32'(rd_valid1), 32'd0);
        rd(4'd5);
        chk("busy_drop_d", 32'(rd_data0), 32'd0);

        // 6: reset with a read in flight, then reset mid-clear at address 9
        wr(4'd9, 16'hC3C3, 2'b11);
        rd(4'd9);
        do_reset();
        rst = 1'b0;
        repeat (9) tick();
        do_reset();
        release_and_clear(n);
        chk("clr_len_restart", 32'(n), 32'd16);

        // Random traffic with frequent same-address collisions
        for (int c = 0; c < 2000; c++) begin
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = AW'($urandom_range(0, DEPTH - 1));
            wr_data = DW'($urandom);
            wr_be   = NB'($urandom_range(0, 3));
            rd_en   = 1'($urandom_range(0, 1));
            rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, DEPTH - 1));
            tick();
        end
        idle();
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
